lab4_readout_sched: RTL

- Sequences readout of the per-LAB4 sample FIFOs onto one shared output stream toward the event buffer and wishbone RAM window.
- Driven by the readout request, header, prescale and test-pattern controls from lab4d_controller.
- Returns a completion pulse to lab4d_controller.
- Arbitrates the single output port across NUM_LABS FIFOs in ascending index order and skips masked LABs.

---
 rtl/lab4_readout_sched_pkg.sv | 38 +++
 rtl/lab4_readout_sched_next_lab.sv | 29 ++
 rtl/lab4_readout_sched.sv | 276 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/lab4_readout_sched_pkg.sv
// Shared definitions for the LAB4 readout scheduler.
//   - state_e        : scheduler FSM states
//   - header layout  : {nibble[15:12], test_pattern[11], event_cnt[10:0]}
//   - test pattern   : {lab[15:10], word[9:0]}
//   - PAD_WORD_DEFAULT : filler emitted after an empty-FIFO timeout
package lab4_readout_sched_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_HEADER,
        ST_DATA,
        ST_NEXT,
        ST_DONE
    } state_e;

    localparam int unsigned HDR_NIB_LSB = 12;
    localparam int unsigned HDR_TP_BIT  = 11;
    localparam int unsigned HDR_CNT_W   = 11;

    localparam int unsigned TP_LAB_LSB  = 10;
    localparam int unsigned TP_WORD_W   = 10;

    localparam int unsigned LAB_IDX_W   = 6;

    localparam logic [15:0] PAD_WORD_DEFAULT = 16'hDEAD;

    function automatic logic [15:0] make_header(input logic [3:0]           nib,
                                                input logic                 tp,
                                                input logic [HDR_CNT_W-1:0] cnt);
        return {nib, tp, cnt};
    endfunction

    function automatic logic [15:0] make_tp_word(input logic [LAB_IDX_W-1:0] lab,
                                                 input logic [TP_WORD_W-1:0] w);
        return {lab, w};
    endfunction

endpackage

// File: rtl/lab4_readout_sched_next_lab.sv
// Combinational priority finder: returns the lowest enabled LAB index that
// is >= start_i, or none_o=1 when no enabled LAB remains.
//   mask_i  : per-LAB enable mask
//   start_i : first index to consider (7 bits so "last index + 1" fits)
//   idx_o   : next enabled index (0 when none_o)
//   none_o  : no enabled LAB at or above start_i
module lab4_next_lab
    import lab4_readout_sched_pkg::*;
#(
    parameter int unsigned NUM_LABS = 24
) (
    input  logic [NUM_LABS-1:0]  mask_i,
    input  logic [6:0]           start_i,
    output logic [LAB_IDX_W-1:0] idx_o,
    output logic                 none_o
);

    always_comb begin
        idx_o  = '0;
        none_o = 1'b1;
        for (int unsigned i = 0; i < NUM_LABS; i++) begin
            if (none_o && mask_i[i] && (i >= 32'(start_i))) begin
                idx_o  = LAB_IDX_W'(i);
                none_o = 1'b0;
            end
        end
    end

endmodule

// File: rtl/lab4_readout_sched.sv
// LAB4 readout scheduler: streams one header word followed by WORDS_PER_LAB
// words from each enabled LAB FIFO (ascending index) onto a single
// valid/ready output toward the event buffer.
//   clk_i, rst_i          : clock, asynchronous active-low reset
//   readout_i             : readout request (prescaled)
//   readout_header_i      : header nibble, latched on accept
//   test_pattern_i        : synthetic data mode, latched on accept
//   prescale_i            : accept 1 of every prescale_i+1 requests
//   lab_mask_i            : LAB enables, latched on accept
//   abort_i               : synchronous abort back to idle
//   fifo_empty_i/dat_i    : per-LAB FWFT FIFO status and data
//   fifo_rd_o             : one-hot pop, coincident with output load
//   m_dat_o/valid_o/last_o, m_ready_i : registered output stream
//   busy_o, complete_o, dropped_o, timeout_o, event_cnt_o : status
module lab4_readout_sched
    import lab4_readout_sched_pkg::*;
#(
    parameter int unsigned           NUM_LABS      = 24,
    parameter int unsigned           DATA_WIDTH    = 16,
    parameter int unsigned           WORDS_PER_LAB = 1024,
    parameter int unsigned           TIMEOUT       = 4096,
    parameter logic [DATA_WIDTH-1:0] PAD_WORD      = PAD_WORD_DEFAULT
) (
    input  logic                           clk_i,
    input  logic                           rst_i,
    input  logic                           readout_i,
    input  logic [3:0]                     readout_header_i,
    input  logic                           test_pattern_i,
    input  logic [3:0]                     prescale_i,
    input  logic [NUM_LABS-1:0]            lab_mask_i,
    input  logic                           abort_i,
    input  logic [NUM_LABS-1:0]            fifo_empty_i,
    input  logic [NUM_LABS*DATA_WIDTH-1:0] fifo_dat_i,
    output logic [NUM_LABS-1:0]            fifo_rd_o,
    output logic [DATA_WIDTH-1:0]          m_dat_o,
    output logic                           m_valid_o,
    output logic                           m_last_o,
    input  logic                           m_ready_i,
    output logic                           busy_o,
    output logic                           complete_o,
    output logic                           dropped_o,
    output logic                           timeout_o,
    output logic [15:0]                    event_cnt_o
);

    localparam int unsigned TO_W = $clog2(TIMEOUT + 1);

    state_e                  state_q, state_d;
    logic [3:0]              psc_q, psc_d;
    logic [3:0]              hdr_q, hdr_d;
    logic                    tp_q, tp_d;
    logic [NUM_LABS-1:0]     mask_q, mask_d;
    logic [LAB_IDX_W-1:0]    lab_q, lab_d;
    logic [TP_WORD_W-1:0]    w_q, w_d;
    logic [TO_W-1:0]         wait_q, wait_d;
    logic                    pad_q, pad_d;
    logic [DATA_WIDTH-1:0]   m_dat_q, m_dat_d;
    logic                    m_valid_q, m_valid_d;
    logic                    m_last_q, m_last_d;
    logic                    complete_q, complete_d;
    logic                    timeout_q, timeout_d;
    logic [15:0]             event_cnt_q, event_cnt_d;

    logic [NUM_LABS-1:0]     fifo_rd;
    logic                    load_en;
    logic                    last_w;
    logic                    advance;

    logic                    cur_empty;
    logic [DATA_WIDTH-1:0]   cur_dat;
    logic [NUM_LABS-1:0]     lab_onehot;

    logic [6:0]              find_start;
    logic [LAB_IDX_W-1:0]    find_idx;
    logic                    find_none;

    // HEADER searches from LAB 0; DATA/NEXT look past the current LAB, which
    // lets the final data word carry m_last without an extra cycle.
    assign find_start = (state_q == ST_HEADER) ? 7'd0 : ({1'b0, lab_q} + 7'd1);

    lab4_next_lab #(
        .NUM_LABS (NUM_LABS)
    ) u_next_lab (
        .mask_i  (mask_q),
        .start_i (find_start),
        .idx_o   (find_idx),
        .none_o  (find_none)
    );

    always_comb begin
        cur_empty  = 1'b1;
        cur_dat    = '0;
        lab_onehot = '0;
        for (int unsigned i = 0; i < NUM_LABS; i++) begin
            if (lab_q == LAB_IDX_W'(i)) begin
                cur_empty     = fifo_empty_i[i];
                cur_dat       = fifo_dat_i[i*DATA_WIDTH +: DATA_WIDTH];
                lab_onehot[i] = 1'b1;
            end
        end
    end

    assign load_en = !m_valid_q || m_ready_i;
    assign last_w  = (w_q == TP_WORD_W'(WORDS_PER_LAB - 1));

    always_comb begin
        state_d     = state_q;
        psc_d       = psc_q;
        hdr_d       = hdr_q;
        tp_d        = tp_q;
        mask_d      = mask_q;
        lab_d       = lab_q;
        w_d         = w_q;
        wait_d      = wait_q;
        pad_d       = pad_q;
        m_dat_d     = m_dat_q;
        m_valid_d   = m_valid_q;
        m_last_d    = m_last_q;
        complete_d  = 1'b0;
        timeout_d   = timeout_q;
        event_cnt_d = event_cnt_q;
        fifo_rd     = '0;
        advance     = 1'b0;

        // An accepted word leaves the register empty unless reloaded below.
        if (load_en) begin
            m_valid_d = 1'b0;
        end

        if (abort_i) begin
            state_d   = ST_IDLE;
            m_valid_d = 1'b0;
            m_last_d  = 1'b0;
        end else begin
            unique case (state_q)
                ST_IDLE: begin
                    if (readout_i) begin
                        if (psc_q == 4'd0) begin
                            psc_d     = prescale_i;
                            hdr_d     = readout_header_i;
                            tp_d      = test_pattern_i;
                            mask_d    = lab_mask_i;
                            timeout_d = 1'b0;
                            state_d   = ST_HEADER;
                        end else begin
                            psc_d      = psc_q - 4'd1;
                            complete_d = 1'b1;
                        end
                    end
                end

                ST_HEADER: begin
                    if (load_en) begin
                        m_dat_d   = make_header(hdr_q, tp_q, event_cnt_q[HDR_CNT_W-1:0]);
                        m_valid_d = 1'b1;
                        m_last_d  = find_none;
                        if (find_none) begin
                            state_d = ST_DONE;
                        end else begin
                            lab_d   = find_idx;
                            w_d     = '0;
                            wait_d  = '0;
                            pad_d   = 1'b0;
                            state_d = ST_DATA;
                        end
                    end
                end

                ST_DATA: begin
                    // Nothing here advances while the output register is
                    // full, so the timeout count pauses under backpressure.
                    if (load_en) begin
                        if (tp_q) begin
                            m_dat_d = make_tp_word(lab_q, w_q);
                            advance = 1'b1;
                        end else if (pad_q) begin
                            m_dat_d = PAD_WORD;
                            advance = 1'b1;
                        end else if (!cur_empty) begin
                            m_dat_d = cur_dat;
                            fifo_rd = lab_onehot;
                            advance = 1'b1;
                        end else if (wait_q == TO_W'(TIMEOUT - 1)) begin
                            pad_d     = 1'b1;
                            timeout_d = 1'b1;
                        end else begin
                            wait_d = wait_q + 1'b1;
                        end

                        if (advance) begin
                            m_valid_d = 1'b1;
                            m_last_d  = last_w && find_none;
                            wait_d    = '0;
                            if (last_w) begin
                                state_d = ST_NEXT;
                            end else begin
                                w_d = w_q + 1'b1;
                            end
                        end
                    end
                end

                ST_NEXT: begin
                    if (find_none) begin
                        state_d = ST_DONE;
                    end else begin
                        lab_d   = find_idx;
                        w_d     = '0;
                        wait_d  = '0;
                        pad_d   = 1'b0;
                        state_d = ST_DATA;
                    end
                end

                ST_DONE: begin
                    // Only the final word can be in the register here, so
                    // load_en means it is gone or leaving this cycle.
                    if (load_en) begin
                        complete_d  = 1'b1;
                        event_cnt_d = event_cnt_q + 16'd1;
                        state_d     = ST_IDLE;
                    end
                end

                default: state_d = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state_q     <= ST_IDLE;
            psc_q       <= '0;
            hdr_q       <= '0;
            tp_q        <= 1'b0;
            mask_q      <= '0;
            lab_q       <= '0;
            w_q         <= '0;
            wait_q      <= '0;
            pad_q       <= 1'b0;
            m_dat_q     <= '0;
            m_valid_q   <= 1'b0;
            m_last_q    <= 1'b0;
            complete_q  <= 1'b0;
            timeout_q   <= 1'b0;
            event_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            psc_q       <= psc_d;
            hdr_q       <= hdr_d;
            tp_q        <= tp_d;
            mask_q      <= mask_d;
            lab_q       <= lab_d;
            w_q         <= w_d;
            wait_q      <= wait_d;
            pad_q       <= pad_d;
            m_dat_q     <= m_dat_d;
            m_valid_q   <= m_valid_d;
            m_last_q    <= m_last_d;
            complete_q  <= complete_d;
            timeout_q   <= timeout_d;
            event_cnt_q <= event_cnt_d;
        end
    end

    assign fifo_rd_o   = fifo_rd;
    assign m_dat_o     = m_dat_q;
    assign m_valid_o   = m_valid_q;
    assign m_last_o    = m_last_q;
    assign busy_o      = (state_q != ST_IDLE);
    assign complete_o  = complete_q;
    assign dropped_o   = readout_i && (state_q != ST_IDLE) && !abort_i;
    assign timeout_o   = timeout_q;
    assign event_cnt_o = event_cnt_q;

endmodule
